reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised multi-port integer register file with an integrated busy scoreboard for the five-stage pipeline. It serves decode-stage operand reads, writeback-stage writes and issue-time destination tracking, so hazard logic can detect pending producers without a separate scoreboard. It replaces the fixed 32x32, two-read, one-write, negedge-write register file. Writes are clocked on the rising edge, with same-cycle write-through bypass to all read ports.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, at least 2; AW = $clog2(NREGS)
- NRP, 2, number of read ports, at least 1
- NWP, 1, number of write ports, 1 or 2; a higher index has higher priority

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- raddr  in  NRP x AW  read addresses
- rdata  out  NRP x XLEN  read data (combinational)
- rbusy  out  NRP  pending-write flag for each read address (combinational)
- wen  in  NWP  write enables
- waddr  in  NWP x AW  write addresses
- wdata  in  NWP x XLEN  write data
- iss_valid  in  1  an instruction with a destination issues this cycle
- iss_rd  in  AW  destination register of the issuing instruction
- flush  in  1  pipeline flush; clears all busy bits

## Operation
- Storage is regs[0..NREGS-1], each XLEN bits wide, plus busy[0..NREGS-1].
- Register 0 is hardwired:
  - rdata is 0 and rbusy is 0 whenever raddr is 0.
  - Writes to address 0 are discarded.
  - An issue to address 0 is ignored.
- Write: at the rising edge, for each port p with wen[p]=1 and waddr[p]!=0, regs[waddr[p]] <= wdata[p].
  - If two ports target the same register, the highest-index port wins.
- Read bypass: rdata[i] is wdata[p] of the highest-index port p with wen[p]=1 and waddr[p]==raddr[i]!=0.
  - Otherwise rdata[i] is regs[raddr[i]].
- Scoreboard, next-state rule for busy[r] (r != 0), applied in priority order:
  1. flush=1: busy[r] <= 0. An issue in the same cycle is discarded.
  2. iss_valid=1 and iss_rd==r: busy[r] <= 1. Set wins over a same-cycle writeback clear, because the new producer is younger.
  3. Any wen[p]=1 with waddr[p]==r: busy[r] <= 0.
  4. Otherwise busy[r] holds.
- rbusy bypass: rbusy[i] is busy[raddr[i]], masked to 0 when a same-cycle write targets raddr[i].
  - A same-cycle issue does not set rbusy; it is reflected from the next cycle onward.
- Multiple outstanding producers of one register are not counted. The first writeback clears busy, and the issue stage must not issue a second writer while busy is set.
- Out-of-range addresses cannot occur, because NREGS is a power of two.

## Timing
- Reset (rst_n=0, asynchronous): all regs are 0 and all busy bits are 0 immediately.
  - rdata is 0 and rbusy is 0 for every address while reset is asserted.
  - Writes, issues and flush are ignored while rst_n=0.
  - Deassertion is synchronised externally; the first active edge is the first rising edge after rst_n goes high.
- Read latency is 0 cycles (combinational), including bypass.
- Write-to-array latency is 1 edge. A write is visible through bypass in the same cycle and from the array from the next cycle.
- Issue-to-busy latency is 1 edge.
- Writeback-to-not-busy: rbusy drops in the same cycle through the bypass, and busy is cleared at the edge.
- Reset asserted mid-operation: all state is lost at once, and any in-flight write in that cycle is not committed.

## Test plan
- Reset: drive wen=1, waddr=5, wdata=32'hDEADBEEF with rst_n=0 across an edge, then release -> raddr=5 gives rdata=0 and rbusy=0.
- Write and bypass: wen=1, waddr=3, wdata=32'h12345678 with raddr[0]=3 -> rdata[0]=32'h12345678 in the same cycle, and from the array after the edge with wen=0.
- x0 and collision (NWP=2):
  - Write 32'hFFFFFFFF to x0 -> reads 0.
  - Both ports write x7 with 32'h1 and 32'h2 -> rdata=32'h2 in the same cycle and after the edge.
- Scoreboard: iss_valid=1, iss_rd=9 -> rbusy=0 in that cycle and 1 from the next cycle; writeback to x9 -> rbusy=0 combinationally and busy cleared after the edge.
- Simultaneous set and clear: busy[4]=1, with writeback to x4 and an issue to x4 in the same cycle -> rbusy=0 in that cycle and rbusy=1 after the edge.
- Flush and mid-operation reset:
  - Flush with issue to x6 and busy set on x2, x6 -> all rbusy=0 after the edge.
  - Assert rst_n=0 mid-cycle -> register contents read 0 immediately.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port integer register file with write-through bypass
// and an issue/writeback busy scoreboard; x0 is hardwired to zero and never busy.
module reg_file_sb #(
   parameter int XLEN = 32,
   parameter int NREGS = 32,
   parameter int NRP = 2,
   parameter int NWP = 1,
   localparam int AW = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRP*AW-1:0]   raddr,
   output logic [NRP*XLEN-1:0] rdata,
   output logic [NRP-1:0]      rbusy,
   input  logic [NWP-1:0]      wen,
   input  logic [NWP*AW-1:0]   waddr,
   input  logic [NWP*XLEN-1:0] wdata,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_rd,
   input  logic                flush
);
   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int p = 0; p < NWP; p++)
         if (wen[p]) begin
            regs_d[waddr[p*AW +: AW]] = wdata[p*XLEN +: XLEN];
            busy_d[waddr[p*AW +: AW]] = 1'b0;
         end
      // a younger producer's set overrides the same-cycle writeback clear
      if (iss_valid) busy_d[iss_rd] = 1'b1;
      if (flush) busy_d = '0;
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      rdata = '0;
      rbusy = '0;
      for (int i = 0; i < NRP; i++) begin
         rdata[i*XLEN +: XLEN] = regs_q[raddr[i*AW +: AW]];
         rbusy[i] = busy_q[raddr[i*AW +: AW]];
         for (int p = 0; p < NWP; p++)
            if (wen[p] && waddr[p*AW +: AW] == raddr[i*AW +: AW] && raddr[i*AW +: AW] != '0) begin
               rdata[i*XLEN +: XLEN] = wdata[p*XLEN +: XLEN];
               rbusy[i] = 1'b0;
            end
      end
      // bypass must not leak write data while the array is held in reset
      if (!rst_n) begin
         rdata = '0;
         rbusy = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         regs_q <= '{default: '0};
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench for reg_file_sb with two read and two write ports.
module tb_reg_file_sb;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  raddr = '0;
   logic [63:0] rdata;
   logic [1:0]  rbusy;
   logic [1:0]  wen = '0;
   logic [9:0]  waddr = '0;
   logic [63:0] wdata = '0;
   logic        iss_valid = 1'b0;
   logic [4:0]  iss_rd = '0;
   logic        flush = 1'b0;

   typedef struct {
      string       nm;
      int          port;
      logic [31:0] d;
      logic        b;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int total = 0;
   int bad = 0;
   logic [31:0] m_regs [32];
   logic [31:0] m_busy;

   reg_file_sb #(.XLEN(32), .NREGS(32), .NRP(2), .NWP(2)) dut (
      .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
      .wen(wen), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
      .iss_rd(iss_rd), .flush(flush)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   task automatic idle();
      wen = '0;
      iss_valid = 1'b0;
      flush = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      wen = 2'b01;
      waddr = {5'd0, 5'd5};
      wdata = {32'h0, 32'hDEADBEEF};
      raddr = {5'd5, 5'd5};
      sb.push_back('{"rst_held", 0, 32'h0, 1'b0});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      sb.push_back('{"rst_x5_p0", 0, 32'h0, 1'b0});
      sb.push_back('{"rst_x5_p1", 1, 32'h0, 1'b0});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
         end
      end
   endtask

   task automatic test_write_bypass();
      @(negedge clk);
      wen = 2'b01;
      waddr = {5'd0, 5'd3};
      wdata = {32'h0, 32'h12345678};
      raddr = {5'd3, 5'd3};
      sb.push_back('{"wr_bypass", 0, 32'h12345678, 1'b0});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
         end
      end
      @(negedge clk);
      idle();
      sb.push_back('{"wr_array_p0", 0, 32'h12345678, 1'b0});
      sb.push_back('{"wr_array_p1", 1, 32'h12345678, 1'b0});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
         end
      end
   endtask

   task automatic test_x0_collision();
      @(negedge clk);
      wen = 2'b10;
      waddr = {5'd0, 5'd0};
      wdata = {32'hFFFFFFFF, 32'h0};
      raddr = {5'd0, 5'd0};
      sb.push_back('{"x0_bypass", 0, 32'h0, 1'b0});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
         end
      end
      @(negedge clk);
      wen = 2'b11;
      waddr = {5'd7, 5'd7};
      wdata = {32'h2, 32'h1};
      raddr = {5'd7, 5'd0};
      sb.push_back('{"x0_array", 1, 32'h2, 1'b0});
      sb.push_back('{"x0_after", 0, 32'h0, 1'b0});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
         end
      end
      @(negedge clk);
      idle();
      raddr = {5'd7, 5'd7};
      sb.push_back('{"coll_array_p0", 0, 32'h2, 1'b0});
      sb.push_back('{"coll_array_p1", 1, 32'h2, 1'b0});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
         end
      end
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      iss_valid = 1'b1;
      iss_rd = 5'd9;
      raddr = {5'd9, 5'd9};
      sb.push_back('{"iss_same_cycle", 0, 32'h0, 1'b0});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
         end
      end
      @(negedge clk);
      idle();
      sb.push_back('{"iss_busy", 0, 32'h0, 1'b1});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
         end
      end
      @(negedge clk);
      wen = 2'b10;
      waddr = {5'd9, 5'd0};
      wdata = {32'hAAAA5555, 32'h0};
      sb.push_back('{"wb_bypass_clear", 0, 32'hAAAA5555, 1'b0});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
         end
      end
      @(negedge clk);
      idle();
      sb.push_back('{"wb_cleared", 1, 32'hAAAA5555, 1'b0});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
         end
      end
   endtask

   task automatic test_set_clear();
      @(negedge clk);
      iss_valid = 1'b1;
      iss_rd = 5'd4;
      raddr = {5'd4, 5'd4};
      @(negedge clk);
      wen = 2'b01;
      waddr = {5'd0, 5'd4};
      wdata = {32'h0, 32'h00000444};
      iss_rd = 5'd4;
      sb.push_back('{"setclr_same", 0, 32'h00000444, 1'b0});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
         end
      end
      @(negedge clk);
      idle();
      sb.push_back('{"setclr_after", 0, 32'h00000444, 1'b1});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
         end
      end
   endtask

   task automatic test_flush();
      @(negedge clk);
      iss_valid = 1'b1;
      iss_rd = 5'd2;
      @(negedge clk);
      iss_rd = 5'd6;
      @(negedge clk);
      idle();
      raddr = {5'd6, 5'd2};
      sb.push_back('{"pre_flush_x2", 0, 32'h0, 1'b1});
      sb.push_back('{"pre_flush_x6", 1, 32'h0, 1'b1});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
         end
      end
      @(negedge clk);
      flush = 1'b1;
      iss_valid = 1'b1;
      iss_rd = 5'd6;
      @(negedge clk);
      idle();
      sb.push_back('{"flush_x2", 0, 32'h0, 1'b0});
      sb.push_back('{"flush_x6", 1, 32'h0, 1'b0});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
         end
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      wen = 2'b01;
      waddr = {5'd0, 5'd10};
      wdata = {32'h0, 32'h55AA55AA};
      iss_valid = 1'b1;
      iss_rd = 5'd11;
      @(negedge clk);
      wen = 2'b01;
      waddr = {5'd0, 5'd12};
      wdata = {32'h0, 32'h0BADF00D};
      iss_valid = 1'b0;
      raddr = {5'd11, 5'd10};
      sb.push_back('{"pre_rst_x10", 0, 32'h55AA55AA, 1'b0});
      sb.push_back('{"pre_rst_x11", 1, 32'h0, 1'b1});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
         end
      end
      #1;
      rst_n = 1'b0;
      sb.push_back('{"mid_rst_x10", 0, 32'h0, 1'b0});
      sb.push_back('{"mid_rst_x11", 1, 32'h0, 1'b0});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      raddr = {5'd11, 5'd12};
      sb.push_back('{"rst_drop_x12", 0, 32'h0, 1'b0});
      sb.push_back('{"rst_drop_x11", 1, 32'h0, 1'b0});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
         end
      end
   endtask

   task automatic test_random();
      logic [4:0]  ra [2];
      logic [4:0]  wa [2];
      logic [31:0] wd [2];
      logic [31:0] xd;
      logic        xb;
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      m_busy = '0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            ra[k] = 5'($urandom_range(0, 31));
            wa[k] = ($urandom_range(0, 3) == 0) ? ra[$urandom_range(0, 1)] : 5'($urandom_range(0, 31));
            wd[k] = $urandom;
         end
         wen = 2'($urandom_range(0, 3));
         raddr = {ra[1], ra[0]};
         waddr = {wa[1], wa[0]};
         wdata = {wd[1], wd[0]};
         iss_valid = ($urandom_range(0, 2) != 0);
         iss_rd = ($urandom_range(0, 3) == 0) ? wa[0] : 5'($urandom_range(0, 31));
         flush = ($urandom_range(0, 19) == 0);
         for (int k = 0; k < 2; k++) begin
            xd = m_regs[ra[k]];
            xb = m_busy[ra[k]];
            if (ra[k] != 0 && wen[0] && wa[0] == ra[k]) begin xd = wd[0]; xb = 1'b0; end
            if (ra[k] != 0 && wen[1] && wa[1] == ra[k]) begin xd = wd[1]; xb = 1'b0; end
            if (ra[k] == 0) begin xd = '0; xb = 1'b0; end
            sb.push_back('{$sformatf("rand%0d_p%0d", n, k), k, xd, xb});
         end
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (rdata[e.port*32 +: 32] !== e.d || rbusy[e.port] !== e.b) begin
               bad++;
               $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", e.nm, rdata[e.port*32 +: 32], rbusy[e.port], e.d, e.b);
            end
         end
         for (int p = 0; p < 2; p++)
            if (wen[p] && wa[p] != 0) begin
               m_regs[wa[p]] = wd[p];
               m_busy[wa[p]] = 1'b0;
            end
         if (flush) m_busy = '0;
         else if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      end
      @(negedge clk);
      idle();
   endtask

   initial begin
      test_reset();
      test_write_bypass();
      test_x0_collision();
      test_scoreboard();
      test_set_clear();
      test_flush();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
